// File: rtl/wdt_host_ctrl.sv
// Bus-side control block for a watchdog: register file, stretched kick/load strobes,
// and a synchronized timeout flag with sticky status and interrupt.
module wdt_host_ctrl #(
    parameter int HOLD_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    output logic        WTOCNT_load,
    input  logic        WTO,
    output logic        irq
);

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_WAIT  = 2'd1;
    localparam logic [1:0] B_ACK   = 2'd2;
    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_LOAD  = 2'd1;
    localparam logic [1:0] L_GUARD = 2'd2;

    localparam logic [3:0] A_CTRL  = 4'h0;
    localparam logic [3:0] A_KICK  = 4'h4;
    localparam logic [3:0] A_WTO   = 4'h8;
    localparam logic [3:0] A_STAT  = 4'hC;
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYC - 1);

    logic [1:0]  bus_q, bus_d;
    logic [1:0]  ld_q, ld_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic [3:0]  kick_cnt_q, kick_cnt_d;
    logic        wdlive_q, wdlive_d;
    logic        wtocnt_load_q, wtocnt_load_d;
    logic [31:0] wtocnt_q, wtocnt_d;
    logic        wden_q, wden_d;
    logic        irqen_q, irqen_d;
    logic        to_q, to_d;
    logic        irq_q;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  wto_sync_q;
    logic        wto_prev_q;

    logic        wto_wr_s;
    logic        go_ack_s;
    logic        wr_s;
    logic        wto_rise_s;
    logic [31:0] rd_mux_s;

    assign wto_wr_s   = req & we & (addr == A_WTO);
    assign wr_s       = go_ack_s & we;
    assign wto_rise_s = wto_sync_q[1] & ~wto_prev_q;

    // Bus FSM: a reload write stalls in B_WAIT until the load sequence has finished
    always_comb begin
        bus_d    = bus_q;
        go_ack_s = 1'b0;
        case (bus_q)
            B_IDLE: begin
                if (req) begin
                    if (wto_wr_s && (ld_q != L_IDLE)) begin
                        bus_d = B_WAIT;
                    end else begin
                        bus_d    = B_ACK;
                        go_ack_s = 1'b1;
                    end
                end else begin
                    bus_d = B_IDLE;
                end
            end
            B_WAIT: begin
                if (ld_q == L_IDLE) begin
                    bus_d    = B_ACK;
                    go_ack_s = 1'b1;
                end else begin
                    bus_d = B_WAIT;
                end
            end
            B_ACK:   bus_d = B_IDLE;
            default: bus_d = B_IDLE;
        endcase
    end

    // Read data mux, sampled on the edge that raises ack
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr)
            A_CTRL:  rd_mux_s = {30'd0, irqen_q, wden_q};
            A_WTO:   rd_mux_s = wtocnt_q;
            A_STAT:  rd_mux_s = {29'd0, wdlive_q, (ld_q != L_IDLE), to_q};
            default: rd_mux_s = 32'd0;
        endcase
        if (go_ack_s && !we) begin
            rdata_d = rd_mux_s;
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Load FSM: strobe high for HOLD_CYC cycles, then a low guard of HOLD_CYC cycles
    always_comb begin
        ld_d          = ld_q;
        ld_cnt_d      = ld_cnt_q;
        wtocnt_load_d = wtocnt_load_q;
        wtocnt_d      = wtocnt_q;
        case (ld_q)
            L_IDLE: begin
                if (wr_s && (addr == A_WTO)) begin
                    wtocnt_d      = wdata;
                    ld_d          = L_LOAD;
                    ld_cnt_d      = HOLD_M1;
                    wtocnt_load_d = 1'b1;
                end else begin
                    wtocnt_load_d = 1'b0;
                end
            end
            L_LOAD: begin
                if (ld_cnt_q == 4'd0) begin
                    ld_d          = L_GUARD;
                    ld_cnt_d      = HOLD_M1;
                    wtocnt_load_d = 1'b0;
                end else begin
                    ld_cnt_d = ld_cnt_q - 4'd1;
                end
            end
            L_GUARD: begin
                if (ld_cnt_q == 4'd0) begin
                    ld_d = L_IDLE;
                end else begin
                    ld_cnt_d = ld_cnt_q - 4'd1;
                end
            end
            default: begin
                ld_d          = L_IDLE;
                ld_cnt_d      = 4'd0;
                wtocnt_load_d = 1'b0;
            end
        endcase
    end

    // Kick stretcher, control bits and sticky timeout (set beats clear)
    always_comb begin
        kick_cnt_d = kick_cnt_q;
        wdlive_d   = wdlive_q;
        wden_d     = wden_q;
        irqen_d    = irqen_q;
        to_d       = to_q;
        if (wdlive_q) begin
            if (kick_cnt_q == 4'd0) begin
                wdlive_d = 1'b0;
            end else begin
                kick_cnt_d = kick_cnt_q - 4'd1;
            end
        end else if (wr_s && (addr == A_KICK) && wdata[0]) begin
            wdlive_d   = 1'b1;
            kick_cnt_d = HOLD_M1;
        end else begin
            wdlive_d = 1'b0;
        end
        if (wr_s && (addr == A_CTRL)) begin
            wden_d  = wdata[0];
            irqen_d = wdata[1];
        end else begin
            wden_d  = wden_q;
        end
        if (wto_rise_s) begin
            to_d = 1'b1;
        end else if (wr_s && (addr == A_STAT) && wdata[0]) begin
            to_d = 1'b0;
        end else begin
            to_d = to_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q         <= B_IDLE;
            ld_q          <= L_IDLE;
            ld_cnt_q      <= 4'd0;
            kick_cnt_q    <= 4'd0;
            wdlive_q      <= 1'b0;
            wtocnt_load_q <= 1'b0;
            wtocnt_q      <= 32'd0;
            wden_q        <= 1'b0;
            irqen_q       <= 1'b0;
            to_q          <= 1'b0;
            irq_q         <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= 32'd0;
            wto_sync_q    <= 2'b00;
            wto_prev_q    <= 1'b0;
        end else begin
            bus_q         <= bus_d;
            ld_q          <= ld_d;
            ld_cnt_q      <= ld_cnt_d;
            kick_cnt_q    <= kick_cnt_d;
            wdlive_q      <= wdlive_d;
            wtocnt_load_q <= wtocnt_load_d;
            wtocnt_q      <= wtocnt_d;
            wden_q        <= wden_d;
            irqen_q       <= irqen_d;
            to_q          <= to_d;
            irq_q         <= to_q & irqen_q;
            ack_q         <= go_ack_s;
            rdata_q       <= rdata_d;
            wto_sync_q    <= {wto_sync_q[0], WTO};
            wto_prev_q    <= wto_sync_q[1];
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign WDEN        = wden_q;
    assign WDLIVE      = wdlive_q;
    assign WTOCNT      = wtocnt_q;
    assign WTOCNT_load = wtocnt_load_q;
    assign irq         = irq_q;

endmodule
